// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential add/subtract block: FSM encoding
// and the ASCII characters that select what the debug LEDs show.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_Z      = 8'h7A;
  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_PIPE   = 8'h7C;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_TILDE  = 8'h7E;
  localparam logic [7:0] CH_DEL    = 8'h7F;

endpackage

// File: rtl/nbit_adder.sv
// Purely combinational ripple-carry adder: {carry, sum} = r1 + r2 + ci.
module nbit_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic c_s;

  // Ripple the carry bit by bit from the LSB
  always_comb begin
    sum = {WIDTH{1'b0}};
    c_s = ci;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = r1[i] ^ r2[i] ^ c_s;
      c_s    = (r1[i] & r2[i]) | (c_s & (r1[i] ^ r2[i]));
    end
    carry = c_s;
  end

endmodule

// File: rtl/param_addsub_seq.sv
// Sequential add/subtract unit: edge-detected request, LAT-clock compute
// delay, RDY_W-clock ready pulse, rejected-request pulse and debug display.
module param_addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 4,
  parameter int RDY_W = 2
) (
  input  logic             i_clk_in,
  input  logic             i_rst,
  input  logic             i_data_rdy,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_r1,
  input  logic [WIDTH-1:0] i_r2,
  input  logic             i_ctrl_signal,
  input  logic [7:0]       i_ctrl,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_rdy,
  output logic             o_busy,
  output logic             o_drop,
  output logic [7:0]       o_debug_led
);

  localparam int              MSB    = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] RDY_LD = CNT_W'(RDY_W - 1);

  state_t            state_r, state_s;
  logic [1:0]        tap_r;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [WIDTH-1:0]  x_r, x_s, y_r, y_s, sum_r, sum_s, add_sum_s;
  logic              cin_r, cin_s, cout_r, cout_s, ovf_r, ovf_s;
  logic              rdy_r, rdy_s, busy_r, busy_s, drop_r, drop_s;
  logic              add_carry_s, req_s;
  logic [1:0]        state_bits_s;
  logic [7:0]        led_r, led_s, sum8_s, x8_s, y8_s, r1_8_s, r2_8_s;

  assign req_s        = tap_r[0] & ~tap_r[1];
  assign state_bits_s = state_r;

  nbit_adder #(.WIDTH(WIDTH)) u_adder (
    .r1    (x_r),
    .r2    (y_r),
    .ci    (cin_r),
    .sum   (add_sum_s),
    .carry (add_carry_s)
  );

  // Debug views are always 8 bits wide; narrow operands are zero-extended
  if (WIDTH >= 8) begin : g_wide
    assign sum8_s = sum_r[7:0];
    assign x8_s   = x_r[7:0];
    assign y8_s   = y_r[7:0];
    assign r1_8_s = i_r1[7:0];
    assign r2_8_s = i_r2[7:0];
  end else begin : g_narrow
    assign sum8_s = {{(8-WIDTH){1'b0}}, sum_r};
    assign x8_s   = {{(8-WIDTH){1'b0}}, x_r};
    assign y8_s   = {{(8-WIDTH){1'b0}}, y_r};
    assign r1_8_s = {{(8-WIDTH){1'b0}}, i_r1};
    assign r2_8_s = {{(8-WIDTH){1'b0}}, i_r2};
  end

  // Next-state and next-datapath logic; requests outside IDLE are dropped
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    x_s     = x_r;
    y_s     = y_r;
    cin_s   = cin_r;
    sum_s   = sum_r;
    cout_s  = cout_r;
    ovf_s   = ovf_r;
    rdy_s   = 1'b0;
    drop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          x_s     = i_r1;
          y_s     = i_sub ? ~i_r2 : i_r2;
          cin_s   = i_sub;
          cnt_s   = LAT_LD;
          state_s = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        drop_s = req_s;
        if (cnt_r == {CNT_W{1'b0}}) begin
          sum_s   = add_sum_s;
          cout_s  = add_carry_s;
          ovf_s   = (x_r[MSB] == y_r[MSB]) & (add_sum_s[MSB] != x_r[MSB]);
          cnt_s   = RDY_LD;
          rdy_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        drop_s = req_s;
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          rdy_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Debug display select; unknown characters hold the current value
  always_comb begin
    led_s = led_r;
    if (i_ctrl_signal) begin
      case (i_ctrl)
        CH_CR:     led_s = {ovf_r, cout_r, sum8_s[5:0]};
        CH_LBRACE: led_s = x8_s;
        CH_RBRACE: led_s = y8_s;
        CH_PIPE:   led_s = r1_8_s;
        CH_TILDE:  led_s = r2_8_s;
        CH_Z:      led_s = {state_bits_s, cnt_r, cin_r, busy_r};
        CH_DEL:    led_s = 8'h00;
        default:   led_s = led_r;
      endcase
    end else begin
      led_s = sum8_s;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, request tap and registered outputs
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      tap_r  <= 2'b00;
      cnt_r  <= {CNT_W{1'b0}};
      x_r    <= {WIDTH{1'b0}};
      y_r    <= {WIDTH{1'b0}};
      cin_r  <= 1'b0;
      sum_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      rdy_r  <= 1'b0;
      busy_r <= 1'b0;
      drop_r <= 1'b0;
      led_r  <= 8'h00;
    end else begin
      tap_r  <= {tap_r[0], i_data_rdy};
      cnt_r  <= cnt_s;
      x_r    <= x_s;
      y_r    <= y_s;
      cin_r  <= cin_s;
      sum_r  <= sum_s;
      cout_r <= cout_s;
      ovf_r  <= ovf_s;
      rdy_r  <= rdy_s;
      busy_r <= busy_s;
      drop_r <= drop_s;
      led_r  <= led_s;
    end
  end

  assign o_sum       = sum_r;
  assign o_cout      = cout_r;
  assign o_ovf       = ovf_r;
  assign o_rdy       = rdy_r;
  assign o_busy      = busy_r;
  assign o_drop      = drop_r;
  assign o_debug_led = led_r;

endmodule

// File: tb/tb_param_addsub_seq.sv
// Directed bench for param_addsub_seq: 8-bit/LAT=4 instance plus a 16-bit/LAT=1 instance.
module tb_param_addsub_seq;

  logic        clk;
  logic        rst;
  logic        d_rdy, sub, ctrl_sig;
  logic [7:0]  r1, r2, ctrl;
  logic [7:0]  sum8, led8;
  logic        cout8, ovf8, rdy8, busy8, drop8;

  logic        w_d_rdy, w_sub, w_ctrl_sig;
  logic [15:0] w_r1, w_r2, w_sum;
  logic [7:0]  w_ctrl, w_led;
  logic        w_cout, w_ovf, w_rdy, w_busy, w_drop;

  int errors = 0;
  int checks = 0;

  param_addsub_seq #(.WIDTH(8), .LAT(4), .RDY_W(2)) u_dut8 (
    .i_clk_in(clk), .i_rst(rst), .i_data_rdy(d_rdy), .i_sub(sub),
    .i_r1(r1), .i_r2(r2), .i_ctrl_signal(ctrl_sig), .i_ctrl(ctrl),
    .o_sum(sum8), .o_cout(cout8), .o_ovf(ovf8), .o_rdy(rdy8),
    .o_busy(busy8), .o_drop(drop8), .o_debug_led(led8)
  );

  param_addsub_seq #(.WIDTH(16), .LAT(1)) u_dut16 (
    .i_clk_in(clk), .i_rst(rst), .i_data_rdy(w_d_rdy), .i_sub(w_sub),
    .i_r1(w_r1), .i_r2(w_r2), .i_ctrl_signal(w_ctrl_sig), .i_ctrl(w_ctrl),
    .o_sum(w_sum), .o_cout(w_cout), .o_ovf(w_ovf), .o_rdy(w_rdy),
    .o_busy(w_busy), .o_drop(w_drop), .o_debug_led(w_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d_rdy = 1'b0; sub = 1'b0; r1 = 8'h00; r2 = 8'h00; ctrl_sig = 1'b0; ctrl = 8'h00;
    w_d_rdy = 1'b0; w_sub = 1'b0; w_r1 = 16'h0; w_r2 = 16'h0; w_ctrl_sig = 1'b0; w_ctrl = 8'h00;
    repeat (3) step();
    checks++;
    if ({sum8, cout8, ovf8, rdy8, busy8, drop8, led8} !== 21'd0) begin
      $display("FAIL reset8: got sum=%h c=%b v=%b rdy=%b busy=%b drop=%b led=%h, want all 0",
               sum8, cout8, ovf8, rdy8, busy8, drop8, led8);
      errors++;
    end
    checks++;
    if ({w_sum, w_cout, w_ovf, w_rdy, w_busy, w_drop, w_led} !== 29'd0) begin
      $display("FAIL reset16: got sum=%h rdy=%b busy=%b led=%h, want all 0", w_sum, w_rdy, w_busy, w_led);
      errors++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_arith();
    logic [7:0] ta[6]   = '{8'h35, 8'h70, 8'hFF, 8'h05, 8'h42, 8'h80};
    logic [7:0] tb[6]   = '{8'h4A, 8'h20, 8'h01, 8'h07, 8'h42, 8'h01};
    logic       ts[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] tsum[6] = '{8'h7F, 8'h90, 8'h00, 8'hFE, 8'h00, 8'h7F};
    logic       tc[6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       tv[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_r, exp_b;
    for (int i = 0; i < 6; i++) begin
      r1 = ta[i]; r2 = tb[i]; sub = ts[i]; d_rdy = 1'b1;
      for (int e = 1; e <= 8; e++) begin
        step();
        if (e == 1) d_rdy = 1'b0;
        exp_r = (e == 6 || e == 7);
        exp_b = (e >= 2 && e <= 7);
        checks++;
        if (rdy8 !== exp_r || busy8 !== exp_b) begin
          $display("FAIL arith[%0d] edge%0d rdy/busy: got %b/%b want %b/%b", i, e, rdy8, busy8, exp_r, exp_b);
          errors++;
        end
        if (e == 6) begin
          checks++;
          if (sum8 !== tsum[i] || cout8 !== tc[i] || ovf8 !== tv[i]) begin
            $display("FAIL arith[%0d] result: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                     i, sum8, cout8, ovf8, tsum[i], tc[i], tv[i]);
            errors++;
          end
        end
      end
    end
  endtask

  // Expects state left by the last arith vector: x=80 y=FE cin=1 sum=7F c=1 v=1
  task automatic test_debug();
    logic       tsig[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] tch[9]  = '{8'h00, 8'h0D, 8'h7B, 8'h7D, 8'h7C, 8'h7E, 8'h7A, 8'h41, 8'h7F};
    logic [7:0] texp[9] = '{8'h7F, 8'hFF, 8'h80, 8'hFE, 8'hA5, 8'h3C, 8'h02, 8'h02, 8'h00};
    r1 = 8'hA5; r2 = 8'h3C;
    for (int i = 0; i < 9; i++) begin
      ctrl_sig = tsig[i]; ctrl = tch[i];
      step();
      checks++;
      if (led8 !== texp[i]) begin
        $display("FAIL debug[%0d] ch=%h: got %h want %h", i, tch[i], led8, texp[i]);
        errors++;
      end
    end
    ctrl = 8'h41;
    step();
    checks++;
    if (led8 !== 8'h00) begin
      $display("FAIL debug hold: got %h want 00", led8);
      errors++;
    end
    ctrl_sig = 1'b0;
  endtask

  task automatic test_hold_level();
    int n_rdy = 0;
    int n_drop = 0;
    r1 = 8'h01; r2 = 8'h02; sub = 1'b0; d_rdy = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 20) d_rdy = 1'b0;
      n_rdy += int'(rdy8);
      n_drop += int'(drop8);
    end
    checks++;
    if (n_rdy != 2 || n_drop != 0) begin
      $display("FAIL hold_level: got rdy_cycles=%0d drops=%0d want 2 and 0", n_rdy, n_drop);
      errors++;
    end
    checks++;
    if (sum8 !== 8'h03) begin
      $display("FAIL hold_level sum: got %h want 03", sum8);
      errors++;
    end
  endtask

  // Second rising edge in CALC and another in the DONE exit cycle; both dropped
  task automatic test_drop();
    logic din[12]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic ebusy[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic erdy[12]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic edrop[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    r1 = 8'h11; r2 = 8'h22; sub = 1'b0;
    for (int e = 0; e < 12; e++) begin
      d_rdy = din[e];
      step();
      if (e == 1) begin
        r1 = 8'h99; r2 = 8'h99;
      end
      checks++;
      if (busy8 !== ebusy[e] || rdy8 !== erdy[e] || drop8 !== edrop[e]) begin
        $display("FAIL drop edge%0d busy/rdy/drop: got %b%b%b want %b%b%b",
                 e + 1, busy8, rdy8, drop8, ebusy[e], erdy[e], edrop[e]);
        errors++;
      end
    end
    checks++;
    if (sum8 !== 8'h33) begin
      $display("FAIL drop sum: got %h want 33", sum8);
      errors++;
    end
  endtask

  task automatic test_reset_midop();
    int n_rdy = 0;
    logic exp_r;
    r1 = 8'h10; r2 = 8'h20; sub = 1'b0; d_rdy = 1'b1;
    step();
    d_rdy = 1'b0;
    repeat (3) step();
    checks++;
    if (busy8 !== 1'b1 || sum8 !== 8'h33) begin
      $display("FAIL midop pre-reset: got busy=%b sum=%h want 1 and 33", busy8, sum8);
      errors++;
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({sum8, cout8, ovf8, rdy8, busy8, drop8, led8} !== 21'd0) begin
      $display("FAIL midop async reset: got sum=%h busy=%b rdy=%b led=%h want all 0", sum8, busy8, rdy8, led8);
      errors++;
    end
    repeat (2) step();
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      n_rdy += int'(rdy8);
    end
    checks++;
    if (n_rdy != 0) begin
      $display("FAIL midop no rdy: got %0d rdy cycles want 0", n_rdy);
      errors++;
    end
    d_rdy = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 1) d_rdy = 1'b0;
      exp_r = (e == 6 || e == 7);
      checks++;
      if (rdy8 !== exp_r) begin
        $display("FAIL midop retry edge%0d rdy: got %b want %b", e, rdy8, exp_r);
        errors++;
      end
      if (e == 6) begin
        checks++;
        if (sum8 !== 8'h30) begin
          $display("FAIL midop retry sum: got %h want 30", sum8);
          errors++;
        end
      end
    end
  endtask

  task automatic test_wide();
    logic exp_r;
    w_r1 = 16'h1234; w_r2 = 16'hEDCC; w_sub = 1'b0; w_d_rdy = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e == 1) w_d_rdy = 1'b0;
      exp_r = (e == 3 || e == 4);
      checks++;
      if (w_rdy !== exp_r) begin
        $display("FAIL wide edge%0d rdy: got %b want %b", e, w_rdy, exp_r);
        errors++;
      end
      if (e == 3) begin
        checks++;
        if (w_sum !== 16'h0000 || w_cout !== 1'b1 || w_ovf !== 1'b0) begin
          $display("FAIL wide result: got sum=%h c=%b v=%b want 0000 1 0", w_sum, w_cout, w_ovf);
          errors++;
        end
      end
    end
    w_ctrl_sig = 1'b1; w_ctrl = 8'h7B;
    step();
    checks++;
    if (w_led !== 8'h34) begin
      $display("FAIL wide debug x: got %h want 34", w_led);
      errors++;
    end
    w_ctrl = 8'h7F;
    step();
    checks++;
    if (w_led !== 8'h00) begin
      $display("FAIL wide debug del: got %h want 00", w_led);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_debug();
    test_hold_level();
    test_drop();
    test_reset_midop();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_addsub_seq.md
PARAM_ADDSUB_SEQ -- requirements
Module: param_addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width (4..32).
REQ-002 SHALL have parameter LAT, default 4, compute latency in clocks (1..15).
REQ-003 SHALL have parameter RDY_W, default 2, o_rdy pulse width in clocks (1..4).
REQ-004 SHALL have port i_clk_in, input, 1, clock.
REQ-005 SHALL have port i_rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port i_data_rdy, input, 1, operands-ready level; may stay high for several cycles.
REQ-007 SHALL have port i_sub, input, 1, 1 = subtract (r1-r2), 0 = add.
REQ-008 SHALL have ports i_r1 and i_r2, input, WIDTH each, operands.
REQ-009 SHALL have ports i_ctrl_signal, input, 1, and i_ctrl, input, 8, debug-select strobe and ASCII character.
REQ-010 SHALL have port o_sum, output, WIDTH, registered result.
REQ-011 SHALL have ports o_cout and o_ovf, output, 1 each: carry-out and signed overflow.
REQ-012 SHALL have ports o_rdy, o_busy and o_drop, output, 1 each: result-ready pulse, operation in flight, and rejected-request pulse.
REQ-013 SHALL have port o_debug_led, output, 8, debug display.

Function
REQ-014 SHALL register i_data_rdy into a 2-bit tap; request = tap[0] & ~tap[1], which yields one request per rising edge.
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-016 In IDLE, a request SHALL capture x = i_r1, y = i_sub ? ~i_r2 : i_r2, cin = i_sub, load the counter with LAT-1, and enter CALC.
REQ-017 In CALC, the counter SHALL decrement each clock; at 0 the block SHALL latch {o_cout, o_sum} = x + y + cin and o_ovf = (x[MSB]==y[MSB]) & (sum[MSB]!=x[MSB]), then enter DONE.
REQ-018 In DONE, o_rdy SHALL be high for exactly RDY_W clocks, then the FSM SHALL return to IDLE.
REQ-019 Latency: o_rdy and the new o_sum SHALL first be visible LAT+2 rising edges after the first edge that samples i_data_rdy high.
REQ-020 For subtract, o_cout SHALL be 1 when i_r1 >= i_r2 (unsigned, no borrow).
REQ-021 o_busy SHALL be high in CALC and DONE.
REQ-022 A request arriving in CALC or DONE SHALL be ignored, operands and result unchanged, and o_drop SHALL pulse for 1 clock.
REQ-023 A request in the same cycle that DONE exits to IDLE SHALL be dropped; a request is accepted only in IDLE.
REQ-024 o_sum, o_cout and o_ovf SHALL hold their values until the next latch.
REQ-025 o_debug_led SHALL be registered; when i_ctrl_signal=1 it SHALL select:
- 0x0D: {o_ovf, o_cout, o_sum[5:0]}
- 0x7B '{': x[7:0]
- 0x7D '}': y[7:0]
- 0x7C '|': i_r1[7:0]
- 0x7E '~': i_r2[7:0]
- 0x7A 'z': {state[1:0], counter[3:0], cin, o_busy}
- 0x7F: 8'h00
- any other character: hold the current value
REQ-026 When i_ctrl_signal=0, o_debug_led SHALL show o_sum[7:0], zero-extended when WIDTH < 8.

Reset
REQ-027 On i_rst high, asynchronously: state=IDLE, tap=0, counter=0, x=y=cin=0, o_sum=0, o_cout=o_ovf=0, o_rdy=o_busy=o_drop=0, o_debug_led=0.
REQ-028 Reset mid-operation SHALL abort with no o_rdy pulse.
REQ-029 After reset release, the first request SHALL require a fresh low-to-high transition of i_data_rdy.

Structure
REQ-030 Package addsub_pkg SHALL hold the FSM state encoding and the ASCII debug-select constants (CR, z, {, |, }, ~, DEL).
REQ-031 Sub-module nbit_adder (parameter WIDTH; ports r1, r2, ci, sum, carry) SHALL be a purely combinational ripple adder, instantiated once.

Verification
REQ-032 WIDTH=8, LAT=4, add: 0x35 + 0x4A -> o_sum 0x7F, cout 0, ovf 0; o_rdy high 2 clocks starting 6 edges after i_data_rdy is sampled high.
REQ-033 Add: 0x70 + 0x20 -> o_sum 0x90, ovf 1, cout 0; 0xFF + 0x01 -> o_sum 0x00, cout 1, ovf 0.
REQ-034 Subtract: 0x05 - 0x07 -> o_sum 0xFE, cout 0; 0x80 - 0x01 -> o_sum 0x7F, ovf 1, cout 1.
REQ-035 i_data_rdy held high 20 clocks -> exactly one o_rdy pulse; a second rising edge during CALC -> o_drop 1-clock pulse, o_sum unchanged.
REQ-036 Assert i_rst 2 clocks into CALC -> all outputs 0 immediately, no o_rdy; the next request completes normally.
REQ-037 WIDTH=16, LAT=1: 0x1234 + 0xEDCC -> o_sum 0x0000, cout 1; debug 0x7B shows 0x34, 0x7F shows 0x00.
